// File: rtl/capture_pkg.sv
// Shared types and constants for the camera pixel capture front end.
// Imported by capture_sync_edge and capture.
package capture_pkg;

    typedef logic [11:0] pixel_t;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        ACTIVE     = 1'b1
    } state_t;

    // Which byte of a pixel pair the next href-high sample carries
    typedef enum logic {
        PH_HIGH = 1'b0,
        PH_LOW  = 1'b1
    } phase_t;

    localparam int CAM_ROW_PIXELS = 640;
    localparam int CAM_ROWS       = 480;

    localparam int H_START  = 159;
    localparam int H_ACTIVE = 480;
    localparam int COL_W    = 10;

    // True when a 0-based column falls inside the kept horizontal window
    function automatic logic in_window(input int col, input int start, input int active);
        return (col >= start) && (col < start + active);
    endfunction

endpackage

// File: rtl/capture_sync_edge.sv
// History registers for vsync/href with single-cycle edge strobes.
// Strobes compare the live input against last cycle's sample, so they
// are valid in the same cycle the new level is first seen.
module capture_sync_edge
    import capture_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    input  logic href,
    output logic vsync_fall,
    output logic href_rise,
    output logic href_fall
);

    logic vsync_q;
    logic href_q;

    // Remember the previous sample of both framing signals
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
        end else begin
            vsync_q <= vsync;
            href_q  <= href;
        end
    end

    assign vsync_fall = vsync_q & ~vsync;
    assign href_rise  = ~href_q & href;
    assign href_fall  = href_q & ~href;

endmodule

// File: rtl/capture.sv
// OV7670-style pixel capture: frames the byte stream with vsync/href,
// pairs bytes into RGB444 pixels, crops each row to a fixed window and
// strobes each kept pixel to the output buffer. Pulses o_sof per frame.
// Optional macro CAPTURE_FRAME_CNT_EN adds a 16-bit wrapping frame
// counter output o_frame_cnt that advances together with o_sof.
module capture #(
    parameter int H_START  = capture_pkg::H_START,
    parameter int H_ACTIVE = capture_pkg::H_ACTIVE,
    parameter int COL_W    = capture_pkg::COL_W
) (
    input  logic        i_pclk,
    input  logic        i_rst,
    input  logic        i_vsync,
    input  logic        i_href,
    input  logic [7:0]  i_data,
    output logic        o_wr,
    output logic [11:0] o_wdata,
    output logic        o_sof
`ifdef CAPTURE_FRAME_CNT_EN
    ,
    output logic [15:0] o_frame_cnt
`endif
);

    import capture_pkg::*;

    localparam logic [COL_W-1:0] COL_MAX = '1;

    state_t           state;
    phase_t           phase;
    logic [COL_W-1:0] col;
    logic [3:0]       red;
    logic             keep;

    logic vsync_fall;
    logic href_rise;
    logic href_fall;

    capture_sync_edge u_sync_edge (
        .clk        (i_pclk),
        .rst        (i_rst),
        .vsync      (i_vsync),
        .href       (i_href),
        .vsync_fall (vsync_fall),
        .href_rise  (href_rise),
        .href_fall  (href_fall)
    );

    assign keep = in_window(int'(col), H_START, H_ACTIVE);

    // Frame FSM plus byte pairing, cropping and registered output strobes
    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            state   <= WAIT_FRAME;
            phase   <= PH_HIGH;
            col     <= '0;
            red     <= '0;
            o_wr    <= 1'b0;
            o_wdata <= '0;
            o_sof   <= 1'b0;
`ifdef CAPTURE_FRAME_CNT_EN
            o_frame_cnt <= '0;
`endif
        end else begin
            o_wr  <= 1'b0;
            o_sof <= 1'b0;
            case (state)
                WAIT_FRAME: begin
                    phase <= PH_HIGH;
                    col   <= '0;
                    if (vsync_fall) begin
                        state <= ACTIVE;
                        o_sof <= 1'b1;
`ifdef CAPTURE_FRAME_CNT_EN
                        o_frame_cnt <= o_frame_cnt + 16'd1;
`endif
                    end
                end
                ACTIVE: begin
                    if (i_vsync) begin
                        state <= WAIT_FRAME;
                        phase <= PH_HIGH;
                        col   <= '0;
                    end else if (href_rise) begin
                        phase <= PH_HIGH;
                        col   <= '0;
                    end else if (i_href) begin
                        if (phase == PH_HIGH) begin
                            red   <= i_data[3:0];
                            phase <= PH_LOW;
                        end else begin
                            if (keep) begin
                                o_wr    <= 1'b1;
                                o_wdata <= {red, i_data};
                            end
                            if (col != COL_MAX) begin
                                col <= col + COL_W'(1);
                            end
                            phase <= PH_HIGH;
                        end
                    end else if (href_fall) begin
                        phase <= PH_HIGH;
                        col   <= '0;
                    end
                end
                default: state <= WAIT_FRAME;
            endcase
        end
    end

endmodule

// File: tb/tb_capture.sv
// Directed testbench for capture: framing, row cropping, vsync abort,
// mid-row reset and (with CAPTURE_FRAME_CNT_EN) the frame counter.
module tb_capture;

    logic        i_pclk;
    logic        i_rst;
    logic        i_vsync;
    logic        i_href;
    logic [7:0]  i_data;
    logic        o_wr;
    logic [11:0] o_wdata;
    logic        o_sof;
`ifdef CAPTURE_FRAME_CNT_EN
    logic [15:0] o_frame_cnt;
`endif

    int total = 0;
    int bad = 0;
    int wr_count = 0;
    int sof_count = 0;
    int exp_frames = 0;
    logic [11:0] exp_q[$];

    capture dut (
        .i_pclk  (i_pclk),
        .i_rst   (i_rst),
        .i_vsync (i_vsync),
        .i_href  (i_href),
        .i_data  (i_data),
        .o_wr    (o_wr),
        .o_wdata (o_wdata),
        .o_sof   (o_sof)
`ifdef CAPTURE_FRAME_CNT_EN
        ,
        .o_frame_cnt (o_frame_cnt)
`endif
    );

    // Free-running pixel clock
    initial begin
        i_pclk = 1'b0;
        forever #5 i_pclk = ~i_pclk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one camera cycle and return just after the sampling edge
    task automatic applyStimulus(input logic rst, input logic vsync, input logic href, input logic [7:0] data);
        i_rst   = rst;
        i_vsync = vsync;
        i_href  = href;
        i_data  = data;
        @(posedge i_pclk);
        #1;
    endtask

    function automatic logic [11:0] pat(input int p);
        if (p == 200) return 12'hABC;
        return 12'((p * 37 + 5) & 32'hFFF);
    endfunction

    // Send a row: dummy byte then npairs pixel pairs, optionally closing it
    task automatic send_row(input int npairs, input bit rnd, input bit capt, input bit end_row, input bit chk200);
        logic [11:0] px;
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hEE);
        for (int p = 0; p < npairs; p++) begin
            px = rnd ? 12'($urandom) : pat(p);
            applyStimulus(1'b0, 1'b0, 1'b1, {4'hF, px[11:8]});
            if (capt && p >= 159 && p < 639) exp_q.push_back(px);
            applyStimulus(1'b0, 1'b0, 1'b1, px[7:0]);
            if (chk200 && p == 200) begin
                checkOutput("pix200_wr", 32'(o_wr), 32'd1);
                checkOutput("pix200_data", 32'(o_wdata), 32'hABC);
            end
        end
        if (end_row) begin
            for (int g = 0; g < 5; g++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        end
    endtask

    // Vsync high for 3 cycles then low: o_sof must pulse exactly once
    task automatic vsync_pulse();
        int s0;
        s0 = sof_count;
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        exp_frames++;
        checkOutput("sof_pulse", 32'(o_sof), 32'd1);
`ifdef CAPTURE_FRAME_CNT_EN
        checkOutput("frame_cnt", 32'(o_frame_cnt), 32'(exp_frames));
`endif
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("sof_one_cycle", 32'(o_sof), 32'd0);
        for (int k = 0; k < 15; k++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("sof_count", 32'(sof_count - s0), 32'd1);
    endtask

    // Observe every write strobe and compare against the expected pixel stream
    always @(negedge i_pclk) begin
        if (o_sof) sof_count++;
        if (o_wr) begin
            wr_count++;
            if (exp_q.size() == 0) checkOutput("excess_write", 32'(exp_q.size()), 32'd1);
            else checkOutput("wdata", 32'(o_wdata), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        int w0;
        i_rst = 1'b1;
        i_vsync = 1'b0;
        i_href = 1'b0;
        i_data = 8'h00;

        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("reset_wr", 32'(o_wr), 32'd0);
        checkOutput("reset_wdata", 32'(o_wdata), 32'd0);
        checkOutput("reset_sof", 32'(o_sof), 32'd0);
`ifdef CAPTURE_FRAME_CNT_EN
        checkOutput("reset_frame_cnt", 32'(o_frame_cnt), 32'd0);
`endif
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

        $display("[TB] row before any frame start");
        w0 = wr_count;
        send_row(639, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("row_no_frame", 32'(wr_count - w0), 32'd0);

        vsync_pulse();

        $display("[TB] full pattern row");
        w0 = wr_count;
        send_row(639, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("row_full", 32'(wr_count - w0), 32'd480);

        w0 = wr_count;
        send_row(100, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("row_100", 32'(wr_count - w0), 32'd0);

        w0 = wr_count;
        send_row(300, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("row_300", 32'(wr_count - w0), 32'd141);

        $display("[TB] vsync mid-row");
        w0 = wr_count;
        send_row(250, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h0F);
        checkOutput("vsync_stop_wr", 32'(o_wr), 32'd0);
        for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b1, 1'b1, 8'hF3);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("vsync_partial", 32'(wr_count - w0), 32'd91);
        vsync_pulse();
        w0 = wr_count;
        send_row(300, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("row_after_vsync", 32'(wr_count - w0), 32'd141);

        $display("[TB] reset mid-row");
        w0 = wr_count;
        send_row(200, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h12);
        exp_frames = 0;
        checkOutput("rst_mid_wr", 32'(o_wr), 32'd0);
        checkOutput("rst_mid_wdata", 32'(o_wdata), 32'd0);
`ifdef CAPTURE_FRAME_CNT_EN
        checkOutput("rst_mid_frame_cnt", 32'(o_frame_cnt), 32'd0);
`endif
        checkOutput("rst_partial", 32'(wr_count - w0), 32'd41);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        w0 = wr_count;
        send_row(639, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("row_after_rst", 32'(wr_count - w0), 32'd0);

        $display("[TB] three frames of random rows");
        for (int f = 0; f < 3; f++) begin
            vsync_pulse();
            for (int r = 0; r < 3; r++) begin
                w0 = wr_count;
                send_row(639, 1'b1, 1'b1, 1'b1, 1'b0);
                checkOutput("frame_row", 32'(wr_count - w0), 32'd480);
            end
        end

        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
